i2c_slave_rx: RTL and testbench

//  Write-only I2C target that consumes the SCL/SDA bus driven by the team's I2C master.

---
 rtl/i2c_pkg.sv | 6 +
 rtl/i2c_bus_sync.sv | 41 ++++
 rtl/i2c_slave_rx.sv | 125 ++++++++++++
 tb/tb_i2c_slave_rx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: widths and FSM state encoding shared by the I2C target and master.
package i2c_pkg;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} i2c_state_e;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronises SCL/SDA into clk and flags SCL edges and START/STOP conditions.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_evt,
   output logic stop_evt
);
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic scl_s, scl_q, sda_q;
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_s      = scl_sync_q[SYNC_STAGES-1];
      sda_s      = sda_sync_q[SYNC_STAGES-1];
      scl_rise   = scl_s & ~scl_q;
      scl_fall   = ~scl_s & scl_q;
      start_evt  = scl_s & scl_q & sda_q & ~sda_s;
      stop_evt   = scl_s & scl_q & ~sda_q & sda_s;
   end
   // Flops reset high so an idle bus produces no spurious edges after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_q      <= 1'b1;
         sda_q      <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_q      <= scl_s;
         sda_q      <= sda_s;
      end
   end
endmodule

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C target; matches a 7-bit address, ACKs and delivers each data byte.
module i2c_slave_rx
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl,
   input  logic              sda_in,
   output logic              sda_pull_low,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              addr_match,
   output logic              busy,
   output logic              frame_done
);
   logic sda_s, scl_rise, scl_fall, start_evt, stop_evt;
   i2c_state_e state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic pull_q, pull_d, match_q, match_d, busy_q, busy_d, got_q, got_d;
   logic rx_valid_q, rx_valid_d, frame_done_q, frame_done_d;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in), .sda_s(sda_s),
      .scl_rise(scl_rise), .scl_fall(scl_fall), .start_evt(start_evt), .stop_evt(stop_evt)
   );

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      pull_d       = pull_q;
      match_d      = match_q;
      busy_d       = busy_q;
      got_d        = got_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      frame_done_d = 1'b0;
      if (start_evt || stop_evt) begin
         state_d      = start_evt ? ADDR : IDLE;
         busy_d       = start_evt;
         bit_cnt_d    = 3'd6;
         shift_d      = '0;
         pull_d       = 1'b0;
         match_d      = 1'b0;
         got_d        = 1'b0;
         frame_done_d = stop_evt & got_q;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d   = {shift_q[DATA_W-2:0], sda_s};
               bit_cnt_d = bit_cnt_q - 3'd1;
               if (bit_cnt_q == 3'd0) state_d = ADDR_ACK;
            end
            // pull_q doubles as the ACK-phase marker: first fall drives, second releases.
            ADDR_ACK: if (scl_fall) begin
               if (pull_q) begin
                  pull_d    = 1'b0;
                  bit_cnt_d = 3'd7;
                  state_d   = DATA;
               end else if (shift_q[ADDR_W-1:0] == SLAVE_ADDR) begin
                  pull_d  = 1'b1;
                  match_d = 1'b1;
               end else begin
                  state_d = IGNORE;
               end
            end
            DATA: if (scl_rise) begin
               shift_d   = {shift_q[DATA_W-2:0], sda_s};
               bit_cnt_d = bit_cnt_q - 3'd1;
               if (bit_cnt_q == 3'd0) begin
                  rx_data_d  = shift_d;
                  rx_valid_d = 1'b1;
                  got_d      = 1'b1;
                  state_d    = DATA_ACK;
               end
            end
            DATA_ACK: if (scl_fall) begin
               pull_d = ~pull_q;
               if (pull_q) begin
                  bit_cnt_d = 3'd7;
                  state_d   = DATA;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         pull_q       <= 1'b0;
         match_q      <= 1'b0;
         busy_q       <= 1'b0;
         got_q        <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         pull_q       <= pull_d;
         match_q      <= match_d;
         busy_q       <= busy_d;
         got_q        <= got_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign sda_pull_low = pull_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign addr_match   = match_q;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: behavioural I2C master with open-drain SDA; scoreboard checks rx bytes and frame_done.
module tb_i2c_slave_rx;
   localparam int Q = 5;
   logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
   logic sda_in, sda_pull_low, rx_valid, addr_match, busy, frame_done;
   logic [7:0] rx_data;
   int n_tests = 0, n_fail = 0;
   logic [8:0] exp_q[$];
   logic pull_seen = 1'b0, busy_drop = 1'b0;
   logic ack;

   assign sda_in = sda_m & ~sda_pull_low;
   always #10 clk = ~clk;

   i2c_slave_rx dut (
      .clk(clk), .rst(rst), .scl(scl_m), .sda_in(sda_in), .sda_pull_low(sda_pull_low),
      .rx_data(rx_data), .rx_valid(rx_valid), .addr_match(addr_match), .busy(busy),
      .frame_done(frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: each rx_valid / frame_done pulse is matched against the next expected event.
   always @(negedge clk) begin
      logic [8:0] act;
      if (sda_pull_low) pull_seen = 1'b1;
      if (!busy) busy_drop = 1'b1;
      if (rx_valid || frame_done) begin
         act = frame_done ? 9'h100 : {1'b0, rx_data};
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got %0h expected no event", act);
         end else check("sb_event", act, exp_q.pop_front());
      end
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask
   task automatic wr_bit(input logic b);
      sda_m = b; wait_q(); scl_m = 1'b1; wait_q(); wait_q(); scl_m = 1'b0; wait_q();
   endtask
   task automatic send(input logic [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) wr_bit(v[i]);
   endtask
   task automatic ack_slot(output logic a);
      sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q(); a = sda_in; wait_q(); scl_m = 1'b0; wait_q();
   endtask
   task automatic start_c();
      sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q(); sda_m = 1'b0; wait_q(); scl_m = 1'b0; wait_q();
   endtask
   task automatic stop_c();
      sda_m = 1'b0; wait_q(); scl_m = 1'b1; wait_q(); sda_m = 1'b1; wait_q(); wait_q();
   endtask
   task automatic addr_tx(input logic [6:0] a, input logic exp_ack, input string name);
      send({1'b0, a}, 7); ack_slot(ack); check(name, ack, exp_ack);
   endtask
   task automatic byte_tx(input logic [7:0] v, input logic matched, input string name);
      if (matched) exp_q.push_back({1'b0, v});
      send(v, 8); ack_slot(ack); check(name, ack, !matched);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", {sda_pull_low, rx_data, rx_valid, addr_match, busy, frame_done}, 0);
      rst = 1'b0;
      wait_q();
      // 1: matched single byte
      start_c();
      check("t1_busy", busy, 1);
      addr_tx(7'h50, 1'b0, "t1_addr_ack");
      check("t1_addr_match", addr_match, 1);
      byte_tx(8'hA5, 1'b1, "t1_data_ack");
      exp_q.push_back(9'h100);
      stop_c();
      check("t1_idle", {busy, addr_match, sda_pull_low}, 0);
      // 2: address mismatch
      pull_seen = 1'b0;
      start_c();
      addr_tx(7'h23, 1'b1, "t2_addr_nack");
      check("t2_addr_match", addr_match, 0);
      byte_tx(8'hFF, 1'b0, "t2_data_nack");
      stop_c();
      check("t2_never_pulled", pull_seen, 0);
      // 3: three bytes in one frame
      start_c();
      addr_tx(7'h50, 1'b0, "t3_addr_ack");
      byte_tx(8'h01, 1'b1, "t3_ack0");
      byte_tx(8'h80, 1'b1, "t3_ack1");
      byte_tx(8'h3C, 1'b1, "t3_ack2");
      exp_q.push_back(9'h100);
      stop_c();
      // 4: repeated START keeps busy high
      start_c();
      busy_drop = 1'b0;
      addr_tx(7'h50, 1'b0, "t4_addr_ack0");
      byte_tx(8'h5A, 1'b1, "t4_ack0");
      start_c();
      check("t4_match_cleared", addr_match, 0);
      addr_tx(7'h50, 1'b0, "t4_addr_ack1");
      byte_tx(8'hC3, 1'b1, "t4_ack1");
      check("t4_busy_held", busy_drop, 0);
      exp_q.push_back(9'h100);
      stop_c();
      check("t4_rx_data", rx_data, 8'hC3);
      // 5: STOP mid-byte discards the partial byte
      start_c();
      addr_tx(7'h50, 1'b0, "t5_addr_ack");
      send(8'h0B, 4);
      stop_c();
      check("t5_idle", {busy, addr_match, sda_pull_low, rx_data}, {3'b000, 8'hC3});
      start_c();
      addr_tx(7'h50, 1'b0, "t5_addr_ack2");
      byte_tx(8'h77, 1'b1, "t5_ack");
      exp_q.push_back(9'h100);
      stop_c();
      // 6: reset while the target is driving the address ACK
      start_c();
      send(8'h50, 7);
      check("t6_ack_driven", sda_pull_low, 1);
      sda_m = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_rst_outputs", {sda_pull_low, rx_data, rx_valid, addr_match, busy, frame_done}, 0);
      scl_m = 1'b1;
      wait_q();
      rst = 1'b0;
      wait_q();
      start_c();
      addr_tx(7'h50, 1'b0, "t6_addr_ack");
      byte_tx(8'h99, 1'b1, "t6_ack");
      exp_q.push_back(9'h100);
      stop_c();
      check("t6_rx_data", rx_data, 8'h99);
      wait_q();
      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
